// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_LD = 2'd1;
  localparam logic [1:0] GNT_DM = 2'd2;
  localparam logic [1:0] GNT_IF = 2'd3;
  localparam int FAIR_W = 3;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection among loader, data and fetch
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int FAIR_LIMIT = 4
) (
  input  logic              ld_active,
  input  logic              ld_req,
  input  logic              dm_req,
  input  logic              if_req,
  input  logic [FAIR_W-1:0] fair_cnt,
  output logic [1:0]        gnt
);
  logic if_due;
  assign if_due = if_req && fair_cnt == FAIR_W'(FAIR_LIMIT);
  // loader first; ld_active masks the core; a starved fetch overrides data
  always_comb
    gnt = ld_req ? GNT_LD : ld_active ? GNT_NONE : (dm_req && !if_due) ? GNT_DM : if_req ? GNT_IF : GNT_NONE;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences the single-port RAM among loader, data port and fetch
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_active,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        ld_ack,
  output logic        dm_ack,
  output logic        if_ack,
  output logic [31:0] rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        ram_cs,
  output logic        ram_we,
  output logic        ram_oe,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        align_err
);
  localparam int CW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [FAIR_W-1:0] fair_cnt;
  logic [1:0] gnt;
  logic sel_we;
  logic [31:0] sel_addr, sel_wdata;
  mem_arb_pick #(.FAIR_LIMIT(FAIR_LIMIT)) u_pick (
    .ld_active(ld_active),
    .ld_req(ld_req),
    .dm_req(dm_req),
    .if_req(if_req),
    .fair_cnt(fair_cnt),
    .gnt(gnt)
  );
  // route the winner's request fields to the grant latch; fetch is always a read
  always_comb begin
    sel_we = gnt == GNT_LD ? ld_we : gnt == GNT_DM ? dm_we : 1'b0;
    sel_addr = gnt == GNT_LD ? ld_addr : gnt == GNT_DM ? dm_addr : if_addr;
    sel_wdata = gnt == GNT_LD ? ld_wdata : dm_wdata;
  end
  // access FSM: the registered RAM strobes and grant id double as the grant latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      fair_cnt <= '0;
      ld_ack <= 1'b0;
      dm_ack <= 1'b0;
      if_ack <= 1'b0;
      rdata <= '0;
      ram_addr <= '0;
      ram_wdata <= '0;
      ram_cs <= 1'b0;
      ram_we <= 1'b0;
      ram_oe <= 1'b0;
      busy <= 1'b0;
      grant_id <= GNT_NONE;
      align_err <= 1'b0;
    end else begin
      ld_ack <= 1'b0;
      dm_ack <= 1'b0;
      if_ack <= 1'b0;
      align_err <= 1'b0;
      case (state)
        IDLE: begin
          fair_cnt <= (gnt == GNT_IF || !if_req) ? '0 : (gnt == GNT_DM && fair_cnt != '1) ? fair_cnt + 1'b1 : fair_cnt;
          if (gnt != GNT_NONE) begin
            state <= ACCESS;
            cnt <= '0;
            busy <= 1'b1;
            grant_id <= gnt;
            ram_cs <= 1'b1;
            ram_we <= sel_we;
            ram_oe <= !sel_we;
            ram_addr <= {sel_addr[31:2], 2'b00};
            ram_wdata <= sel_we ? sel_wdata : '0;
            align_err <= |sel_addr[1:0];
          end
        end
        ACCESS: begin
          if (cnt == CW'(ACCESS_CYCLES - 1)) begin
            state <= DONE;
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
            ram_oe <= 1'b0;
            ram_addr <= '0;
            ram_wdata <= '0;
            rdata <= ram_oe ? ram_rdata : rdata;
            ld_ack <= grant_id == GNT_LD;
            dm_ack <= grant_id == GNT_DM;
            if_ack <= grant_id == GNT_IF;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          grant_id <= GNT_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single-port word RAM (cs/we/oe, 32-bit address and data) and shares it between three requesters: the boot loader, the CPU data port (LDR/STR) and the CPU instruction fetch. Each access is one full RAM transaction: the grant is latched, the RAM is held for a fixed number of cycles, and the winner is acknowledged. The block sits between the core's memory stage and fetch stage, the boot loader, and the RAM model.

## Interface
- `ACCESS_CYCLES`, default 2: cycles the RAM strobes are held per access; must be 1 or more.
- `FAIR_LIMIT`, default 4: maximum number of consecutive data grants while a fetch is pending.
- `clk` in 1: single clock; all state is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ld_active` in 1: loader owns memory; data and fetch requests are ignored while it is high.
- `ld_req`, `ld_we` in 1; `ld_addr`, `ld_wdata` in 32: loader request.
- `dm_req`, `dm_we` in 1; `dm_addr`, `dm_wdata` in 32: data-port request.
- `if_req` in 1; `if_addr` in 32: fetch request, read only.
- `ld_ack`, `dm_ack`, `if_ack` out 1: one-cycle completion pulse to the winner.
- `rdata` out 32: read data; valid in the ack cycle and held until the next read completes.
- `ram_addr`, `ram_wdata` out 32; `ram_rdata` in 32; `ram_cs`, `ram_we`, `ram_oe` out 1: RAM port.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out 2: 0 none, 1 loader, 2 data, 3 fetch.
- `align_err` out 1: one-cycle pulse when the latched address has bits [1:0] nonzero.

## Operation
- States and transitions:
  - IDLE: when any eligible request is present, go to ACCESS.
  - ACCESS: hold for `ACCESS_CYCLES` cycles, then go to DONE.
  - DONE: always return to IDLE after one cycle.
- Priority:
  - Loader is highest priority.
  - Data beats fetch, except when the fairness counter equals `FAIR_LIMIT` and `if_req` is high. Fetch then wins.
- Fairness counter (3+ bits, saturating):
  - Increments on each data grant made while `if_req` is high.
  - Clears on a fetch grant, or on any IDLE cycle with `if_req` low.
- Grant latch (IDLE exit): captures the winner id, its `we` (fetch forces 0), `wdata`, and its address with bits [1:0] forced to 0. `align_err` pulses in that same cycle if the original bits [1:0] were nonzero.
- ACCESS outputs:
  - `ram_cs`=1 and `ram_addr` driven from the latch.
  - Write: `ram_we`=1, `ram_oe`=0, `ram_wdata` driven from the latch.
  - Read: `ram_oe`=1, `ram_we`=0.
  - `ram_we` and `ram_oe` are never both 1.
- Read capture: on the last ACCESS cycle, `ram_rdata` is registered into `rdata`. Writes leave `rdata` unchanged.
- DONE: the winner's ack is 1; RAM strobes are 0.
- Requester rules:
  - Hold `req`, `addr`, `wdata` and `we` stable until ack. The block samples them only at the IDLE exit.
  - Dropping `req` early does not abort the access; the ack still pulses.
  - Keeping `req` high after ack requests a new access, which is arbitrated in the following IDLE.
- Simultaneous events:
  - `ld_active` rising during a data or fetch access lets that access complete; the loader wins the next IDLE.
  - `ld_req` without `ld_active` is still served, at loader priority.

## Timing
- Request seen in IDLE cycle N: ACCESS runs in cycles N+1 through N+`ACCESS_CYCLES`, and the ack plus `rdata` appear in cycle N+`ACCESS_CYCLES`+1.
- Throughput: one access every `ACCESS_CYCLES`+2 cycles (4 at the default).
- `grant_id` is valid from N+1 through the DONE cycle, and 0 in IDLE.
- Reset values: all outputs 0, including `rdata`, `ram_*`, `grant_id` and `busy`; state is IDLE and the fairness counter is 0.
- Asynchronous reset mid-access drops the strobes and ack immediately. The access is aborted and is not retried.

## Structure
- Package `mem_arb_pkg`:
  - State enum: IDLE, ACCESS, DONE.
  - Grant-id constants: GNT_NONE, GNT_LD, GNT_DM, GNT_IF.
  - Width of the fairness counter.
- Sub-module `mem_arb_pick`: combinational winner selection from the requests, `ld_active` and the fairness count.
- The FSM, latch, cycle counter and fairness counter live in the top module.

## Test plan
- Loader writes 0xE3A00001 to address 0, then reads address 0 back. Required: `ld_ack` at N+3; `ram_we`=1 for exactly 2 cycles on the write; `rdata`=0xE3A00001 on the read.
- Same-cycle `dm_req` (read of address 0x10) and `if_req` (address 0x0). Required: data is acked first, then fetch, 4 cycles apart.
- `dm_req` held high continuously with `if_req` high. Required: fetch wins after the 4th consecutive data grant.
- `ld_active`=1 with `dm_req` and `if_req` high. Required: no `dm_ack` or `if_ack` until `ld_active` falls.
- `dm_addr`=0x1002 write. Required: `align_err` pulses once and `ram_addr`=0x1000.
- `rst_n` low in the first ACCESS cycle. Required: `ram_cs`, `ram_we` and `ram_oe` drop immediately; no ack follows; `busy`=0.
